lsu_data_memory: RTL and testbench

LSU_DATA_MEMORY -- requirements
Module: lsu_data_memory

---
 rtl/lsu_data_memory.sv | 135 +++++++++++++
 tb/tb_lsu_data_memory.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_data_memory.sv
// Byte-addressed little-endian data memory behind a load/store handshake with configurable response latency.
// Optional misalignment checking is enabled by defining DMEM_MISALIGN_CHECK_EN.
module lsu_data_memory #(
    parameter int DEPTH_BYTES = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    output logic        ready,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        rvalid,
    output logic [31:0] rdata,
    output logic        err
);
    localparam int AW = $clog2(DEPTH_BYTES);
    localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {INIT, IDLE, WAIT, RESP} state_t;

    state_t          state, next_state;
    logic [AW-1:0]   init_idx;
    logic [2:0]      wait_cnt;
    logic [31:0]     rdata_q;

    logic            we_p0, uns_p0;
    logic [1:0]      size_p0;
    logic [AW-1:0]   addr_p0;
    logic [31:0]     wdata_p0;

    logic [7:0]      mem [DEPTH_BYTES];
    logic            accept, misaligned, commit;
    logic [3:0]      lane_en;
    logic [31:0]     raw_word, resp_data;
    logic            unused_addr_hi;

    // Only the low AW address bits select a byte; higher bits alias.
    assign unused_addr_hi = ^addr[31:AW];

    function automatic logic [31:0] extend(input logic [31:0] word, input logic [1:0] sz,
                                           input logic zero_ext);
        case (sz)
            2'b00:   return {{24{~zero_ext & word[7]}}, word[7:0]};
            2'b01:   return {{16{~zero_ext & word[15]}}, word[15:0]};
            default: return word;
        endcase
    endfunction

    assign ready  = (state == IDLE);
    assign rvalid = (state == RESP);
    assign accept = req && ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= INIT;
            init_idx <= '0;
            wait_cnt <= '0;
            rdata_q  <= '0;
        end else begin
            state <= next_state;
            if (state == INIT)
                init_idx <= init_idx + 1'b1;
            if (accept)
                wait_cnt <= '0;
            else if (state == WAIT)
                wait_cnt <= wait_cnt + 1'b1;
            if (state == RESP)
                rdata_q <= resp_data;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            INIT: if (init_idx == '1) next_state = IDLE;
            IDLE: if (req) next_state = (WAIT_CYCLES > 0) ? WAIT : RESP;
            WAIT: if (wait_cnt == WAIT_LAST) next_state = RESP;
            RESP: next_state = IDLE;
            default: next_state = INIT;
        endcase
    end

    // Stage p0: request captured at accept, consumed in RESP
    always_ff @(posedge clk) begin
        if (accept) begin
            we_p0    <= we;
            uns_p0   <= uns;
            size_p0  <= size;
            addr_p0  <= addr[AW-1:0];
            wdata_p0 <= wdata;
        end
    end

`ifdef DMEM_MISALIGN_CHECK_EN
    assign misaligned = ((size_p0 == 2'b01) && addr_p0[0]) ||
                        (size_p0[1] && (addr_p0[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign err    = rvalid && misaligned;
    assign commit = (state == RESP) && we_p0 && !misaligned;

    always_comb begin
        case (size_p0)
            2'b00:   lane_en = 4'b0001;
            2'b01:   lane_en = 4'b0011;
            default: lane_en = 4'b1111;
        endcase
    end

    // Each byte lane wraps independently modulo the memory size.
    always_comb begin
        raw_word = '0;
        for (int i = 0; i < 4; i++)
            raw_word[8*i +: 8] = mem[addr_p0 + AW'(i)];
    end

    assign resp_data = (we_p0 || misaligned) ? 32'h0 : extend(raw_word, size_p0, uns_p0);
    assign rdata     = rvalid ? resp_data : rdata_q;

    always_ff @(posedge clk) begin
        if (state == INIT)
            mem[init_idx] <= 8'h00;
        if (commit) begin
            for (int i = 0; i < 4; i++)
                if (lane_en[i])
                    mem[addr_p0 + AW'(i)] <= wdata_p0[8*i +: 8];
        end
    end
endmodule

// File: tb/tb_lsu_data_memory.sv
// Directed bench for lsu_data_memory: vector table on a WAIT_CYCLES=1 instance plus
// hand-written sequences for latency, back-pressure and reset-abandon behaviour.
module tb_lsu_data_memory;
    localparam int DEPTH_A = 1024;
    localparam int WAIT_A  = 1;
    localparam int DEPTH_B = 16;
    localparam int WAIT_B  = 3;
`ifdef DMEM_MISALIGN_CHECK_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    logic        a_req, a_we, a_uns, a_ready, a_rvalid, a_err;
    logic [1:0]  a_size;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic        b_req, b_we, b_uns, b_ready, b_rvalid, b_err;
    logic [1:0]  b_size;
    logic [31:0] b_addr, b_wdata, b_rdata;

    always #5 clk = ~clk;

    lsu_data_memory #(.DEPTH_BYTES(DEPTH_A), .WAIT_CYCLES(WAIT_A)) dut_a (
        .clk(clk), .reset(reset), .req(a_req), .ready(a_ready), .we(a_we), .size(a_size),
        .uns(a_uns), .addr(a_addr), .wdata(a_wdata), .rvalid(a_rvalid), .rdata(a_rdata),
        .err(a_err)
    );

    lsu_data_memory #(.DEPTH_BYTES(DEPTH_B), .WAIT_CYCLES(WAIT_B)) dut_b (
        .clk(clk), .reset(reset), .req(b_req), .ready(b_ready), .we(b_we), .size(b_size),
        .uns(b_uns), .addr(b_addr), .wdata(b_wdata), .rvalid(b_rvalid), .rdata(b_rdata),
        .err(b_err)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        vecs.push_back(v);
    endfunction

    // One complete access on instance A; lat counts cycles from accept to rvalid.
    task automatic a_access(input logic we, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rd, output logic er, output int lat);
        int n;
        rd = '0; er = 1'b0; lat = 0;
        @(negedge clk);
        n = 0;
        while (!a_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!a_ready) begin
            check("a_ready_timeout", {31'b0, a_ready}, 32'h1);
            return;
        end
        a_we = we; a_size = size; a_uns = uns; a_addr = addr; a_wdata = wdata;
        a_req = 1'b1;
        @(posedge clk);
        #1 a_req = 1'b0;
        do begin
            @(negedge clk);
            lat++;
        end while (!a_rvalid && lat < 20);
        if (!a_rvalid) begin
            check("a_rvalid_timeout", {31'b0, a_rvalid}, 32'h1);
            return;
        end
        rd = a_rdata;
        er = a_err;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          cnt;
        logic        seen;

        reset = 1'b1;
        a_req = 0; a_we = 0; a_uns = 0; a_size = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_uns = 0; b_size = 0; b_addr = 0; b_wdata = 0;

        add(0, 2'd2, 0, 32'h3FC, 32'h0,        32'h0000_0000, 0);
        add(1, 2'd2, 0, 32'h010, 32'hDEADBEEF, 32'h0000_0000, 0);
        add(0, 2'd0, 1, 32'h010, 32'h0,        32'h0000_00EF, 0);
        add(0, 2'd0, 1, 32'h011, 32'h0,        32'h0000_00BE, 0);
        add(0, 2'd0, 1, 32'h012, 32'h0,        32'h0000_00AD, 0);
        add(0, 2'd0, 1, 32'h013, 32'h0,        32'h0000_00DE, 0);
        add(0, 2'd0, 0, 32'h013, 32'h0,        32'hFFFF_FFDE, 0);
        add(0, 2'd0, 0, 32'h010, 32'h0,        32'hFFFF_FFEF, 0);
        add(1, 2'd2, 0, 32'h020, 32'hAAAAAAAA, 32'h0000_0000, 0);
        add(1, 2'd1, 0, 32'h022, 32'hFFFF1234, 32'h0000_0000, 0);
        add(0, 2'd2, 0, 32'h020, 32'h0,        32'h1234_AAAA, 0);
        add(0, 2'd1, 0, 32'h020, 32'h0,        32'hFFFF_AAAA, 0);
        add(0, 2'd1, 1, 32'h022, 32'h0,        32'h0000_1234, 0);
        add(1, 2'd0, 0, 32'h030, 32'h12345680, 32'h0000_0000, 0);
        add(0, 2'd2, 0, 32'h030, 32'h0,        32'h0000_0080, 0);
        add(0, 2'd0, 0, 32'h030, 32'h0,        32'hFFFF_FF80, 0);
        add(1, 2'd2, 0, 32'h101, 32'hCAFEF00D, 32'h0000_0000, MIS);
        add(0, 2'd0, 1, 32'h101, 32'h0,        MIS ? 32'h0 : 32'h0000_000D, 0);
        add(0, 2'd0, 1, 32'h104, 32'h0,        MIS ? 32'h0 : 32'h0000_00CA, 0);
        add(0, 2'd2, 0, 32'h100, 32'h0,        MIS ? 32'h0 : 32'hFEF0_0D00, 0);
        add(0, 2'd2, 0, 32'h101, 32'h0,        MIS ? 32'h0 : 32'hCAFE_F00D, MIS);
        add(0, 2'd1, 1, 32'h021, 32'h0,        MIS ? 32'h0 : 32'h0000_34AA, MIS);
        add(1, 2'd2, 0, 32'h3FE, 32'h11223344, 32'h0000_0000, MIS);
        add(0, 2'd0, 1, 32'h3FE, 32'h0,        MIS ? 32'h0 : 32'h0000_0044, 0);
        add(0, 2'd0, 1, 32'h3FF, 32'h0,        MIS ? 32'h0 : 32'h0000_0033, 0);
        add(0, 2'd1, 1, 32'h000, 32'h0,        MIS ? 32'h0 : 32'h0000_1122, 0);
        add(0, 2'd0, 1, 32'h002, 32'h0,        32'h0000_0000, 0);
        add(0, 2'd3, 0, 32'h010, 32'h0,        32'hDEAD_BEEF, 0);

        // Reset state and INIT duration
        repeat (3) @(negedge clk);
        check("rst_ready",  {31'b0, a_ready},  32'h0);
        check("rst_rvalid", {31'b0, a_rvalid}, 32'h0);
        check("rst_rdata",  a_rdata,           32'h0);
        check("rst_err",    {31'b0, a_err},    32'h0);
        reset = 1'b0;
        cnt = 0;
        while (!a_ready && cnt < 1100) begin
            @(posedge clk);
            #1 cnt++;
        end
        check("ready_rise_cycle", 32'(cnt + 1), 32'(DEPTH_A + 1));

        foreach (vecs[i]) begin
            a_access(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                     rd, er, lat);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(WAIT_A + 1));
        end

        // rdata holds after the strobe; err stays low without rvalid
        repeat (3) @(negedge clk);
        check("hold_rdata",  a_rdata,           32'hDEAD_BEEF);
        check("hold_rvalid", {31'b0, a_rvalid}, 32'h0);
        check("hold_err",    {31'b0, a_err},    32'h0);

        // WAIT_CYCLES=3: req held through the busy window
        @(negedge clk);
        check("b_ready_idle", {31'b0, b_ready}, 32'h1);
        b_we = 1; b_size = 2'd2; b_uns = 0; b_addr = 32'h4; b_wdata = 32'h55667788;
        b_req = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check($sformatf("b_ready_n%0d", k), {31'b0, b_ready}, 32'h0);
            check($sformatf("b_rvalid_n%0d", k), {31'b0, b_rvalid}, (k == 4) ? 32'h1 : 32'h0);
            if (k == 4) begin
                check("b_store_rdata", b_rdata, 32'h0);
                b_we = 0; b_addr = 32'h4;
            end
        end
        @(negedge clk);
        check("b_ready_n5", {31'b0, b_ready}, 32'h1);
        @(posedge clk);
        #1 b_req = 1'b0;
        @(negedge clk);
        check("b_ready_n6", {31'b0, b_ready}, 32'h0);
        cnt = 0;
        while (!b_rvalid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("b_second_latency", 32'(cnt), 32'(WAIT_B));
        check("b_load_rdata", b_rdata, 32'h5566_7788);

        // Reset during the WAIT state of a store abandons it
        @(negedge clk);
        a_we = 1; a_size = 2'd2; a_uns = 0; a_addr = 32'h200; a_wdata = 32'h12345678;
        a_req = 1'b1;
        @(posedge clk);
        #1 a_req = 1'b0;
        @(negedge clk);
        check("mid_wait_ready", {31'b0, a_ready}, 32'h0);
        reset = 1'b1;
        #1;
        check("mid_rst_rdata",  a_rdata,           32'h0);
        check("mid_rst_rvalid", {31'b0, a_rvalid}, 32'h0);
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen = seen | a_rvalid;
        end
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | a_rvalid;
        end
        check("mid_rst_no_rvalid", {31'b0, seen}, 32'h0);
        a_access(0, 2'd2, 0, 32'h200, 32'h0, rd, er, lat);
        check("abandoned_store_word", rd, 32'h0);
        a_access(0, 2'd2, 0, 32'h010, 32'h0, rd, er, lat);
        check("post_reset_zero", rd, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
